// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default line constants.
// Used by both the receiver and the transmitter FSMs.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    localparam int UART_CLK_HZ     = 12000000;
    localparam int UART_BAUD       = 9600;
    localparam int UART_OVERSAMPLE = 16;

    // Clocks per oversample tick, never less than one.
    function automatic int baud_div(input int clk_hz, input int baud, input int oversample);
        int d;
        d = clk_hz / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Byte handshake and error-pulse bundle between the UART receiver and its consumer.
// master = receiver side, slave = consumer side.
interface uart_rx_fsm_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  frame_err;
    logic                  overrun;
    logic                  parity_err;

    modport master (
        output rx_byte, rx_valid, frame_err, overrun, parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_byte, rx_valid, frame_err, overrun, parity_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks,
// synchronously restartable so the first tick is phase-aligned to a start edge.
module uart_baud_tick #(
    parameter int DIV = 78
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter with registered tick output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (restart) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_rx_fsm.sv
// Oversampling UART receiver (8N1 by default) with valid/ready byte delivery.
// Optional parity bit support when UART_RX_PARITY_EN is defined.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_HZ     = UART_CLK_HZ,
    parameter int BAUD       = UART_BAUD,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int PARITY_ODD = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ftdi_rx,
    uart_rx_fsm_if.master rx
);
    localparam int            DIV     = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int            TW      = $clog2(OVERSAMPLE);
    localparam int            BW      = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    // Parity bit a correct transmitter sends for this data word.
    function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    uart_state_e           state_r;
    logic [1:0]            sync_r;
    logic                  prev_r;
    logic [TW-1:0]         tick_cnt_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] rx_byte_r;
    logic                  rx_valid_r;
    logic                  frame_err_r;
    logic                  overrun_r;
`ifdef UART_RX_PARITY_EN
    logic                  par_err_r;
    logic                  par_out_r;
`endif

    logic line_s;
    logic fall_s;
    logic restart_s;
    logic tick_s;

    assign line_s    = sync_r[1];
    assign fall_s    = prev_r & ~line_s;
    assign restart_s = (state_r == ST_IDLE) && fall_s;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Two-flop synchronizer for the asynchronous line plus edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b11;
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[0], ftdi_rx};
            prev_r <= line_s;
        end
    end

    // Receive FSM, shifter and output handshake register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            tick_cnt_r  <= '0;
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            rx_byte_r   <= '0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_r   <= 1'b0;
            par_out_r   <= 1'b0;
`endif
        end else begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            // An accept drops valid unless a delivery below reloads it this cycle.
            if (rx_valid_r && rx.rx_ready) begin
                rx_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_r    <= ST_START;
                        tick_cnt_r <= '0;
                        bit_cnt_r  <= '0;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        if (tick_cnt_r == HALF_M1) begin
                            tick_cnt_r <= '0;
                            state_r    <= line_s ? ST_IDLE : ST_DATA;
                        end else begin
                            tick_cnt_r <= tick_cnt_r + TW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (tick_cnt_r == FULL_M1) begin
                            tick_cnt_r <= '0;
                            shift_r    <= {line_s, shift_r[DATA_WIDTH-1:1]};
                            bit_cnt_r  <= bit_cnt_r + BW'(1);
                            if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_r <= ST_PARITY;
`else
                                state_r <= ST_STOP;
`endif
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + TW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick_s) begin
                        if (tick_cnt_r == FULL_M1) begin
                            tick_cnt_r <= '0;
                            par_err_r  <= (line_s != expected_parity(shift_r));
                            state_r    <= ST_STOP;
                        end else begin
                            tick_cnt_r <= tick_cnt_r + TW'(1);
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_s) begin
                        if (tick_cnt_r == FULL_M1) begin
                            tick_cnt_r <= '0;
                            if (line_s) begin
                                state_r <= ST_IDLE;
                                if (!rx_valid_r || rx.rx_ready) begin
                                    rx_byte_r  <= shift_r;
                                    rx_valid_r <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                    par_out_r  <= par_err_r;
`endif
                                end else begin
                                    overrun_r <= 1'b1;
                                end
                            end else begin
                                frame_err_r <= 1'b1;
                                state_r     <= ST_BREAK;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + TW'(1);
                        end
                    end
                end
                ST_BREAK: begin
                    if (line_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx.rx_byte   = rx_byte_r;
    assign rx.rx_valid  = rx_valid_r;
    assign rx.frame_err = frame_err_r;
    assign rx.overrun   = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign rx.parity_err = par_out_r;
`else
    assign rx.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with a fast line (4 clocks per tick, 64 clocks per bit).
// Adds the parity scenario when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fsm;
    import uart_pkg::*;

    localparam int BIT_CLKS = 64;

    logic clk;
    logic rst_n;
    logic ftdi_rx;

    int tests = 0;
    int fails = 0;

    int valid_cyc = 0;
    int acc_cnt   = 0;
    int ferr_cnt  = 0;
    int ovr_cnt   = 0;
    logic [7:0] last_byte = 8'h00;

    int s_valid, s_acc, s_ferr, s_ovr;

`ifdef UART_RX_PARITY_EN
    logic par_force_en = 1'b0;
    logic par_val      = 1'b0;
`endif

    uart_rx_fsm_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_fsm #(
        .DATA_WIDTH (8),
        .CLK_HZ     (6400000),
        .BAUD       (100000),
        .OVERSAMPLE (16),
        .PARITY_ODD (0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ftdi_rx (ftdi_rx),
        .rx      (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_valid) valid_cyc++;
        if (bus.rx_valid && bus.rx_ready) begin
            acc_cnt++;
            last_byte = bus.rx_byte;
        end
        if (bus.frame_err) ferr_cnt++;
        if (bus.overrun) ovr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ftdi_rx = b;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_force_en ? par_val : (^d));
`endif
        send_bit(stop_b);
    endtask

    task automatic snap();
        s_valid = valid_cyc;
        s_acc   = acc_cnt;
        s_ferr  = ferr_cnt;
        s_ovr   = ovr_cnt;
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        ftdi_rx      = 1'b1;
        bus.rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_byte", 32'(bus.rx_byte), 32'h00);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_parity_err", 32'(bus.parity_err), 32'd0);
        rst_n = 1'b1;
        repeat (3 * BIT_CLKS) @(posedge clk);

        // 1: plain frame, consumer always ready
        snap();
        send_frame(8'hA5, 1'b1);
        send_bit(1'b1);
        settle();
        check("t1_accepts", 32'(acc_cnt - s_acc), 32'd1);
        check("t1_byte", 32'(last_byte), 32'hA5);
        check("t1_valid_cycles", 32'(valid_cyc - s_valid), 32'd1);
        check("t1_frame_err", 32'(ferr_cnt - s_ferr), 32'd0);
        check("t1_overrun", 32'(ovr_cnt - s_ovr), 32'd0);
        check("t1_valid_low", 32'(bus.rx_valid), 32'd0);

        // 2: 5-tick low glitch is a false start
        snap();
        ftdi_rx = 1'b0;
        repeat (20) @(posedge clk);
        ftdi_rx = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge clk);
        @(negedge clk);
        check("t2_state_idle", 32'(dut.state_r), 32'(ST_IDLE));
        check("t2_no_valid", 32'(valid_cyc - s_valid), 32'd0);
        check("t2_no_ferr", 32'(ferr_cnt - s_ferr), 32'd0);
        snap();
        send_frame(8'h3C, 1'b1);
        send_bit(1'b1);
        settle();
        check("t2_accepts", 32'(acc_cnt - s_acc), 32'd1);
        check("t2_byte", 32'(last_byte), 32'h3C);

        // 3: bad stop bit then held-low break
        snap();
        send_frame(8'h3C, 1'b0);
        repeat (30) send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        settle();
        check("t3_one_ferr", 32'(ferr_cnt - s_ferr), 32'd1);
        check("t3_no_valid", 32'(valid_cyc - s_valid), 32'd0);
        snap();
        send_frame(8'h55, 1'b1);
        send_bit(1'b1);
        settle();
        check("t3_accepts", 32'(acc_cnt - s_acc), 32'd1);
        check("t3_byte", 32'(last_byte), 32'h55);

        // 4: back-to-back frames while consumer stalls
        snap();
        bus.rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_bit(1'b1);
        settle();
        check("t4_valid_held", 32'(bus.rx_valid), 32'd1);
        check("t4_byte_kept", 32'(bus.rx_byte), 32'h11);
        check("t4_one_overrun", 32'(ovr_cnt - s_ovr), 32'd1);
        bus.rx_ready = 1'b1;
        settle();
        check("t4_valid_drop", 32'(bus.rx_valid), 32'd0);
        check("t4_accepted_byte", 32'(last_byte), 32'h11);
        check("t4_accepts", 32'(acc_cnt - s_acc), 32'd1);

        // 5: asynchronous reset in data bit 3
        bus.rx_ready = 1'b0;
        send_frame(8'h33, 1'b1);
        send_bit(1'b1);
        settle();
        check("t5_pending", 32'(bus.rx_valid), 32'd1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ftdi_rx = 1'b1;
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(bus.rx_valid), 32'd0);
        check("t5_rst_byte", 32'(bus.rx_byte), 32'h00);
        check("t5_rst_state", 32'(dut.state_r), 32'(ST_IDLE));
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rx_ready = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge clk);
        snap();
        send_frame(8'h5A, 1'b1);
        send_bit(1'b1);
        settle();
        check("t5_accepts", 32'(acc_cnt - s_acc), 32'd1);
        check("t5_byte", 32'(last_byte), 32'h5A);

`ifdef UART_RX_PARITY_EN
        // 6: even parity, wrong then right parity bit
        bus.rx_ready = 1'b0;
        par_force_en = 1'b1;
        par_val      = 1'b0;
        send_frame(8'h07, 1'b1);
        send_bit(1'b1);
        settle();
        check("t6_valid", 32'(bus.rx_valid), 32'd1);
        check("t6_byte", 32'(bus.rx_byte), 32'h07);
        check("t6_perr_set", 32'(bus.parity_err), 32'd1);
        bus.rx_ready = 1'b1;
        settle();
        bus.rx_ready = 1'b0;
        par_val      = 1'b1;
        send_frame(8'h07, 1'b1);
        send_bit(1'b1);
        settle();
        check("t6_valid2", 32'(bus.rx_valid), 32'd1);
        check("t6_perr_clr", 32'(bus.parity_err), 32'd0);
        bus.rx_ready = 1'b1;
        par_force_en = 1'b0;
        settle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
